// File: rtl/systolic1_loader_pkg.sv
// Shared sizing, state encoding and width helper for the systolic1 tile loader.
package systolic1_loader_pkg;

  localparam int LANE_W      = 8;
  localparam int N_LANES_DEF = 1024;
  localparam int BUS_W_DEF   = 32;
  localparam int N_W_DEF     = 9;
  localparam int MAC_LAT_DEF = 4;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEATS  = N_LANES_DEF * LANE_W / BUS_W_DEF;
  localparam int BEAT_W = cnt_w(BEATS);
  localparam int WIDX_W = cnt_w(N_W_DEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/tile_weight_seq.sv
// Per-tile weight file, its active copy for the tile in flight, and the
// sequencer that presents one active weight per streaming cycle on w_r_o.
module tile_weight_seq
  import systolic1_loader_pkg::*;
#(
  parameter int N_W = N_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANE_W-1:0] w_data_i,
  input  logic              w_valid_i,
  input  logic              swap_i,
  input  logic              stream_i,
  output logic              w_ready_o,
  output logic              w_full_o,
  output logic              w_last_o,
  output logic [LANE_W-1:0] w_r_o
);

  localparam int IDX_W = cnt_w(N_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_W - 1);

  logic [LANE_W-1:0] wfile_q [N_W];
  logic [LANE_W-1:0] act_q   [N_W];
  logic [IDX_W-1:0]  fill_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic              w_full_q;
  logic [LANE_W-1:0] w_r_q;
  logic              w_fire;

  assign w_fire    = w_valid_i & ~w_full_q;
  assign idx_d     = idx_q + 1'b1;
  assign w_ready_o = ~w_full_q;
  assign w_full_o  = w_full_q;
  assign w_last_o  = (idx_q == IDX_LAST);
  assign w_r_o     = w_r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_W; i++) wfile_q[i] <= '0;
      fill_q   <= '0;
      w_full_q <= 1'b0;
    end else if (swap_i) begin
      w_full_q <= 1'b0;
    end else if (w_fire) begin
      wfile_q[fill_q] <= w_data_i;
      if (fill_q == IDX_LAST) begin
        fill_q   <= '0;
        w_full_q <= 1'b1;
      end else begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

  // Weight 0 is loaded on the swap edge so it is valid on the first enabled cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_W; i++) act_q[i] <= '0;
      idx_q <= '0;
      w_r_q <= '0;
    end else if (swap_i) begin
      act_q <= wfile_q;
      idx_q <= '0;
      w_r_q <= wfile_q[0];
    end else if (stream_i) begin
      if (idx_q == IDX_LAST) begin
        w_r_q <= '0;
      end else begin
        idx_q <= idx_d;
        w_r_q <= act_q[idx_d];
      end
    end
  end

endmodule

// File: rtl/systolic1_loader.sv
// Activation tile loader for the systolic MAC array: assembles the shadow tile
// from the stream, swaps it into in_r and sequences the tile through the array.
//
// state    | meaning
// S_IDLE   | array gated; swaps when shadow and weights are full (not on tile_done cycle)
// S_STREAM | array enabled, one active weight per cycle on w_r
// S_DRAIN  | array enabled, w_r = 0 for MAC_LAT cycles
module systolic1_loader
  import systolic1_loader_pkg::*;
#(
  parameter int N_LANES = N_LANES_DEF,
  parameter int BUS_W   = BUS_W_DEF,
  parameter int N_W     = N_W_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BUS_W-1:0]          act_data,
  input  logic                      act_valid,
  output logic                      act_ready,
  input  logic [LANE_W-1:0]         w_data,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic                      mode,
  output logic [N_LANES*LANE_W-1:0] in_r,
  output logic [LANE_W-1:0]         w_r,
  output logic                      sel,
  output logic                      stop_proc,
  output logic                      busy,
  output logic                      tile_done
);

  localparam int TILE_W  = N_LANES * LANE_W;
  localparam int N_BEATS = TILE_W / BUS_W;
  localparam int CNT_W   = cnt_w(N_BEATS);
  localparam int LAT_W   = cnt_w(MAC_LAT);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(N_BEATS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MAC_LAT - 1);

  state_t             state_q;
  logic [TILE_W-1:0]  shadow_q;
  logic [TILE_W-1:0]  in_r_q;
  logic [CNT_W-1:0]   beat_q;
  logic [LAT_W-1:0]   drain_q;
  logic               shadow_full_q;
  logic               sel_q;
  logic               stop_q;
  logic               busy_q;
  logic               tile_done_q;
  logic               act_fire;
  logic               swap;
  logic               w_full;
  logic               w_last;

  assign act_fire  = act_valid & ~shadow_full_q;
  assign swap      = (state_q == S_IDLE) & shadow_full_q & w_full & ~tile_done_q;
  assign act_ready = ~shadow_full_q;
  assign in_r      = in_r_q;
  assign sel       = sel_q;
  assign stop_proc = stop_q;
  assign busy      = busy_q;
  assign tile_done = tile_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q      <= '0;
      beat_q        <= '0;
      shadow_full_q <= 1'b0;
    end else if (swap) begin
      shadow_full_q <= 1'b0;
    end else if (act_fire) begin
      shadow_q[beat_q*BUS_W +: BUS_W] <= act_data;
      if (beat_q == BEAT_LAST) begin
        beat_q        <= '0;
        shadow_full_q <= 1'b1;
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  tile_weight_seq #(
    .N_W (N_W)
  ) u_wseq (
    .clk       (clk),
    .rst       (rst),
    .w_data_i  (w_data),
    .w_valid_i (w_valid),
    .swap_i    (swap),
    .stream_i  (state_q == S_STREAM),
    .w_ready_o (w_ready),
    .w_full_o  (w_full),
    .w_last_o  (w_last),
    .w_r_o     (w_r)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      in_r_q      <= '0;
      sel_q       <= 1'b0;
      stop_q      <= 1'b1;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
      drain_q     <= '0;
    end else begin
      tile_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (swap) begin
            in_r_q  <= shadow_q;
            sel_q   <= mode;
            stop_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_last) begin
            drain_q <= LAT_LAST;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_q == '0) begin
            stop_q      <= 1'b1;
            busy_q      <= 1'b0;
            tile_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic1_loader.sv
// Scoreboard bench for systolic1_loader: expected tiles are queued as they are
// fed and compared against in_r / w_r / sel / tile_done as each tile streams.
module tb_systolic1_loader;

  // A short tile (8 beats) lets the next tile fill while one streams.
  localparam int LANES   = 32;
  localparam int BUS_W   = 32;
  localparam int N_W     = 9;
  localparam int MAC_LAT = 4;
  localparam int BEATS   = LANES * 8 / BUS_W;
  localparam int EN_CYC  = N_W + MAC_LAT;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [BUS_W-1:0]     act_data;
  logic                 act_valid;
  logic                 act_ready;
  logic [7:0]           w_data;
  logic                 w_valid;
  logic                 w_ready;
  logic                 mode;
  logic [LANES*8-1:0]   in_r;
  logic [7:0]           w_r;
  logic                 sel;
  logic                 stop_proc;
  logic                 busy;
  logic                 tile_done;

  always #5 clk = ~clk;

  systolic1_loader #(
    .N_LANES (LANES),
    .BUS_W   (BUS_W),
    .N_W     (N_W),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .act_data  (act_data),
    .act_valid (act_valid),
    .act_ready (act_ready),
    .w_data    (w_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .mode      (mode),
    .in_r      (in_r),
    .w_r       (w_r),
    .sel       (sel),
    .stop_proc (stop_proc),
    .busy      (busy),
    .tile_done (tile_done)
  );

  typedef struct packed {
    logic [LANES*8-1:0] img;
    logic [16*8-1:0]    wv;
    logic               sel;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  bit   in_tile = 0;
  bit   bb_on = 0;
  int   last_start = -1;
  int   stalls = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LANES*8-1:0] tile_img(input int pat);
    logic [LANES*8-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*8 +: 8] = 8'((l + pat * 41) & 255);
    return v;
  endfunction

  task automatic push_exp(input int pat, input int wbase, input logic s);
    exp_t e;
    e.img = tile_img(pat);
    e.wv  = '0;
    for (int i = 0; i < N_W; i++) e.wv[i*8 +: 8] = 8'(wbase + i);
    e.sel = s;
    sb_q.push_back(e);
  endtask

  task automatic feed_act(input int pat, input int nbeats);
    logic [LANES*8-1:0] img;
    logic hs;
    int k = 0;
    int guard = 0;
    img = tile_img(pat);
    while (k < nbeats && guard < 1000) begin
      act_valid = 1'b1;
      act_data  = img[k*BUS_W +: BUS_W];
      @(negedge clk);
      hs = act_ready;
      if (!hs) stalls++;
      @(posedge clk);
      #1;
      if (hs) k++;
      guard++;
    end
    act_valid = 1'b0;
    if (k < nbeats) chk("act_feed_timeout", 64'(k), 64'(nbeats));
  endtask

  task automatic feed_w(input int wbase, input int nw);
    logic hs;
    int k = 0;
    int guard = 0;
    while (k < nw && guard < 1000) begin
      w_valid = 1'b1;
      w_data  = 8'(wbase + k);
      @(negedge clk);
      hs = w_ready;
      @(posedge clk);
      #1;
      if (hs) k++;
      guard++;
    end
    w_valid = 1'b0;
    if (k < nw) chk("w_feed_timeout", 64'(k), 64'(nw));
  endtask

  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (n_done < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("done_count", 64'(n_done), 64'(target));
  endtask

  task automatic wait_stream(input int budget);
    int t = 0;
    while (stop_proc && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("stream_start", 64'(stop_proc), 64'(0));
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_r_zero", 64'(in_r == '0), 64'(1));
    chk("rst_w_r", 64'(w_r), 64'(0));
    chk("rst_sel", 64'(sel), 64'(0));
    chk("rst_stop_proc", 64'(stop_proc), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_tile_done", 64'(tile_done), 64'(0));
    chk("rst_act_ready", 64'(act_ready), 64'(1));
    chk("rst_w_ready", 64'(w_ready), 64'(1));
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      in_tile = 0;
      en_cnt  = 0;
    end else if (!stop_proc) begin
      if (!in_tile) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'(0), 64'(1));
          cur = '0;
        end else begin
          cur = sb_q.pop_front();
        end
        in_tile = 1;
        en_cnt  = 0;
        chk("in_r_lane0", 64'(in_r[0 +: 8]), 64'(cur.img[0 +: 8]));
        chk("in_r_lane5", 64'(in_r[5*8 +: 8]), 64'(cur.img[5*8 +: 8]));
        chk("in_r_lane_top", 64'(in_r[(LANES-1)*8 +: 8]), 64'(cur.img[(LANES-1)*8 +: 8]));
        chk("in_r_all", 64'(in_r == cur.img), 64'(1));
        if (bb_on && last_start >= 0) chk("swap_period", 64'(cyc - last_start), 64'(EN_CYC + 2));
        last_start = cyc;
      end
      en_cnt++;
      chk("w_r", 64'(w_r), 64'((en_cnt <= N_W) ? cur.wv[(en_cnt-1)*8 +: 8] : 8'h00));
      chk("sel_hold", 64'(sel), 64'(cur.sel));
      chk("busy_enabled", 64'(busy), 64'(1));
      chk("no_done_enabled", 64'(tile_done), 64'(0));
    end else begin
      if (in_tile) begin
        chk("enabled_cycles", 64'(en_cnt), 64'(EN_CYC));
        chk("tile_done", 64'(tile_done), 64'(1));
        chk("busy_done", 64'(busy), 64'(0));
        n_done++;
        in_tile = 0;
      end else if (tile_done) begin
        chk("tile_done_spurious", 64'(1), 64'(0));
      end
    end
  end

  initial begin
    #300us;
    $display("FAIL watchdog: run exceeded time limit (checks=%0d)", n_chk);
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    act_valid = 1'b0;
    act_data  = '0;
    w_valid   = 1'b0;
    w_data    = '0;
    mode      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Tile aborted by reset mid-stream, with a partial next tile pending.
    push_exp(3, 8'h20, 1'b0);
    fork
      feed_act(3, BEATS);
      feed_w(8'h20, N_W);
    join
    fork
      feed_act(7, 3);
      feed_w(8'h70, 4);
    join
    chk("abort_in_stream", 64'(stop_proc), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_done_after_abort", 64'(n_done), 64'(0));

    // Basic tile: lane bytes = lane index, weights 1..9, mode toggled mid-stream.
    mode = 1'b1;
    push_exp(0, 8'h01, 1'b1);
    fork
      feed_act(0, BEATS);
      feed_w(8'h01, N_W);
    join
    wait_stream(10);
    mode = 1'b0;
    wait_done(1, 100);
    @(negedge clk);
    chk("sel_after_done", 64'(sel), 64'(1));
    chk("lane5_value", 64'(in_r[5*8 +: 8]), 64'(8'h05));

    // Weights arrive late: stays gated until the ninth weight, then swaps.
    @(posedge clk);
    #1;
    push_exp(2, 8'h40, 1'b0);
    feed_act(2, BEATS);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("late_idle_stop", 64'(stop_proc), 64'(1));
    chk("late_idle_busy", 64'(busy), 64'(0));
    chk("late_act_ready_full", 64'(act_ready), 64'(0));
    chk("late_w_ready", 64'(w_ready), 64'(1));
    @(posedge clk);
    #1;
    feed_w(8'h40, N_W);
    @(negedge clk);
    chk("late_swap_cycle_stop", 64'(stop_proc), 64'(1));
    @(negedge clk);
    chk("late_first_enabled", 64'(stop_proc), 64'(0));
    wait_done(2, 100);

    // Back-to-back tiles at full rate with shadow backpressure.
    @(posedge clk);
    #1;
    mode       = 1'b1;
    bb_on      = 1;
    last_start = -1;
    stalls     = 0;
    for (int t = 0; t < 3; t++) push_exp(10 + t, 8'h80 + 16 * t, 1'b1);
    fork
      begin
        for (int t = 0; t < 3; t++) feed_act(10 + t, BEATS);
      end
      begin
        for (int t = 0; t < 3; t++) feed_w(8'h80 + 16 * t, N_W);
      end
    join
    wait_done(5, 200);
    bb_on = 0;
    chk("bp_stalls_seen", 64'(stalls != 0), 64'(1));
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
